// File: rtl/timer_controller.sv
// Countdown timer controller: button-set time, 1 s prescaled countdown while
// the motor runs, one-cycle timeout pulse to the motor FSM on expiry.
module timer_controller #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned STEP     = 5,
    parameter int unsigned TIME_MAX = 30           // must be <= 31
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_time,
    input  logic       i_btn_clear,
    input  logic       i_motor_on,
    output logic [4:0] o_timeState,
    output logic [1:0] o_state,
    output logic       o_timer_run,
    output logic       o_timeout
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARMED  = 2'b01,
        RUN    = 2'b10,
        EXPIRE = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          run_q, timeout_q;
    logic [5:0]    sum;

    assign sum = {1'b0, time_q} + 6'(STEP);

    // Next-state logic: EXPIRE ignores buttons, clear beats time press,
    // any button beats a prescaler terminal count.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        if (state_q == EXPIRE) begin
            state_d = IDLE;
            time_d  = '0;
            presc_d = '0;
        end else if (i_btn_clear) begin
            state_d = IDLE;
            time_d  = '0;
            presc_d = '0;
        end else if (i_btn_time) begin
            presc_d = '0;
            if (sum > 6'(TIME_MAX)) begin
                state_d = IDLE;
                time_d  = '0;
            end else begin
                time_d  = sum[4:0];
                state_d = i_motor_on ? RUN : ARMED;
            end
        end else begin
            case (state_q)
                ARMED: begin
                    presc_d = '0;
                    if (i_motor_on) state_d = RUN;
                end
                RUN: begin
                    if (!i_motor_on) begin
                        state_d = ARMED;
                        presc_d = '0;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (time_q <= 5'd1) begin
                            time_d  = '0;
                            state_d = EXPIRE;
                        end else begin
                            time_d = time_q - 5'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    presc_d = '0;
                    time_d  = '0;
                end
            endcase
        end
    end

    // State, time, prescaler and registered flag outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            time_q    <= '0;
            presc_q   <= '0;
            run_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            presc_q   <= presc_d;
            run_q     <= (state_d == RUN);
            timeout_q <= (state_d == EXPIRE);
        end
    end

    assign o_timeState = time_q;
    assign o_state     = state_q;
    assign o_timer_run = run_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_timer_controller.sv
// Directed bench for timer_controller with CLK_HZ=4, STEP=5, TIME_MAX=30.
module tb_timer_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_time = 1'b0;
    logic       btn_clear = 1'b0;
    logic       motor = 1'b0;
    logic [4:0] time_s;
    logic [1:0] state_s;
    logic       run_s;
    logic       timeout_s;

    int vectors = 0;
    int miscompares = 0;

    timer_controller #(
        .CLK_HZ  (4),
        .STEP    (5),
        .TIME_MAX(30)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_btn_time (btn_time),
        .i_btn_clear(btn_clear),
        .i_motor_on (motor),
        .o_timeState(time_s),
        .o_state    (state_s),
        .o_timer_run(run_s),
        .o_timeout  (timeout_s)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] t, input logic [1:0] s,
                           input logic r, input logic to);
        chk({tag, ".time"}, {3'b0, time_s}, {3'b0, t});
        chk({tag, ".state"}, {6'b0, state_s}, {6'b0, s});
        chk({tag, ".run"}, {7'b0, run_s}, {7'b0, r});
        chk({tag, ".timeout"}, {7'b0, timeout_s}, {7'b0, to});
    endtask

    task automatic press_time();
        btn_time = 1'b1;
        tick();
        btn_time = 1'b0;
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        tick();
        btn_clear = 1'b0;
    endtask

    initial begin
        logic saw_timeout;
        logic [4:0] exp_t;

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1 chk_all("reset_async", 5'd0, 2'b00, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk_all("reset_release", 5'd0, 2'b00, 1'b0, 1'b0);

        // Seven presses with motor off: 5..30 ARMED, then wrap to 0 IDLE
        for (int i = 1; i <= 7; i++) begin
            press_time();
            exp_t = (i <= 6) ? 5'(5 * i) : 5'd0;
            chk_all($sformatf("press%0d", i), exp_t, (i <= 6) ? 2'b01 : 2'b00, 1'b0, 1'b0);
        end

        // Time 5, motor on: countdown every 4 cycles, timeout at EXPIRE
        press_time();
        chk_all("arm5", 5'd5, 2'b01, 1'b0, 1'b0);
        motor = 1'b1;
        tick();
        chk_all("run5", 5'd5, 2'b10, 1'b1, 1'b0);
        for (int t = 5; t >= 1; t--) begin
            repeat (3) tick();
            chk($sformatf("hold%0d", t), {3'b0, time_s}, 8'(t));
            tick();
            if (t > 1) chk_all($sformatf("dec%0d", t - 1), 5'(t - 1), 2'b10, 1'b1, 1'b0);
            else       chk_all("expire", 5'd0, 2'b11, 1'b0, 1'b1);
        end
        // Time press during EXPIRE is ignored
        btn_time = 1'b1;
        tick();
        btn_time = 1'b0;
        chk_all("post_expire", 5'd0, 2'b00, 1'b0, 1'b0);
        tick();
        chk_all("idle_motor_on", 5'd0, 2'b00, 1'b0, 1'b0);

        // Pause at 10 with motor off, then resume
        press_time();
        chk_all("run_set5", 5'd5, 2'b10, 1'b1, 1'b0);
        press_time();
        chk_all("run_set10", 5'd10, 2'b10, 1'b1, 1'b0);
        motor = 1'b0;
        tick();
        chk_all("pause", 5'd10, 2'b01, 1'b0, 1'b0);
        repeat (20) tick();
        chk_all("paused20", 5'd10, 2'b01, 1'b0, 1'b0);
        motor = 1'b1;
        tick();
        chk_all("resume", 5'd10, 2'b10, 1'b1, 1'b0);
        repeat (3) tick();
        chk("resume_hold", {3'b0, time_s}, 8'd10);
        tick();
        chk("resume_dec", {3'b0, time_s}, 8'd9);

        // Clear during RUN: IDLE, no timeout
        press_clear();
        chk_all("clear_run", 5'd0, 2'b00, 1'b0, 1'b0);

        // Time press coincident with terminal count at 10
        press_time();
        press_time();
        chk_all("tc_setup", 5'd10, 2'b10, 1'b1, 1'b0);
        repeat (3) tick();
        chk("tc_pre", {3'b0, time_s}, 8'd10);
        press_time();
        chk_all("tc_override", 5'd15, 2'b10, 1'b1, 1'b0);
        repeat (3) tick();
        chk("tc_presc_cleared", {3'b0, time_s}, 8'd15);
        tick();
        chk("tc_next_dec", {3'b0, time_s}, 8'd14);

        // Clear and time press together: clear wins
        btn_clear = 1'b1;
        btn_time  = 1'b1;
        tick();
        btn_clear = 1'b0;
        btn_time  = 1'b0;
        chk_all("clear_prio", 5'd0, 2'b00, 1'b0, 1'b0);
        tick();
        chk_all("clear_prio_next", 5'd0, 2'b00, 1'b0, 1'b0);

        // Reset between edges during RUN at time 3
        press_time();
        chk_all("rst_setup", 5'd5, 2'b10, 1'b1, 1'b0);
        repeat (8) tick();
        chk_all("rst_at3", 5'd3, 2'b10, 1'b1, 1'b0);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1 chk_all("rst_mid_run", 5'd0, 2'b00, 1'b0, 1'b0);
        #2 rst = 1'b0;
        saw_timeout = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (timeout_s !== 1'b0 || state_s !== 2'b00) saw_timeout = 1'b1;
        end
        chk("rst_no_timeout", {7'b0, saw_timeout}, 8'd0);
        chk_all("rst_after", 5'd0, 2'b00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
